// File: rtl/dlatch_checker_if.sv
// Observation bus between the D-latch stimulus side and the response checker.
// Signal directions are named from the checker's point of view.
interface dlatch_checker_if #(
   parameter int unsigned ERR_W = 8,
   parameter int unsigned CNT_W = 16
) ();
   logic             i_start;
   logic             i_stop;
   logic             i_en;
   logic             i_d;
   logic             i_q;
   logic             i_q_bar;
   logic             o_busy;
   logic             o_done;
   logic             o_pass;
   logic [ERR_W-1:0] o_err_count;
   logic [1:0]       o_first_err;
   logic [CNT_W-1:0] o_sample_count;

   modport master (
      output i_start, i_stop, i_en, i_d, i_q, i_q_bar,
      input  o_busy, o_done, o_pass, o_err_count, o_first_err, o_sample_count
   );

   modport slave (
      input  i_start, i_stop, i_en, i_d, i_q, i_q_bar,
      output o_busy, o_done, o_pass, o_err_count, o_first_err, o_sample_count
   );
endinterface

// File: rtl/dlatch_checker.sv
// Response checker for a D-latch under test: runs a reference latch model beside
// the DUT and counts complement/follow/hold violations, publishing a verdict at stop.
module dlatch_checker #(
   parameter int unsigned SETTLE = 1,
   parameter int unsigned ERR_W  = 8,
   parameter int unsigned CNT_W  = 16
) (
   input  logic            i_clk,
   input  logic            i_reset,
   dlatch_checker_if.slave bus
);
   typedef enum logic [1:0] {S_IDLE, S_ARM, S_CHECK, S_DONE} state_t;

   localparam logic [ERR_W-1:0] ERR_MAX  = '1;
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [1:0]       C_NONE   = 2'b00;
   localparam logic [1:0]       C_COMPL  = 2'b01;
   localparam logic [1:0]       C_FOLLOW = 2'b10;
   localparam logic [1:0]       C_HOLD   = 2'b11;

   state_t            r_state;
   state_t            w_state_nx;
   logic              r_arm_cnt;
   logic              w_arm_cnt_nx;
   logic              w_arm_entry;
   logic              w_model_upd;

   // Stage 0 is the live model; stage SETTLE-1 is the value q is compared against.
   logic [SETTLE-1:0] r_exp;
   logic [SETTLE-1:0] r_gate;
   logic [SETTLE-1:0] r_mvalid;
   logic [SETTLE-1:0] w_exp_nx;
   logic [SETTLE-1:0] w_gate_nx;
   logic [SETTLE-1:0] w_mvalid_nx;

   logic [ERR_W-1:0]  r_err;
   logic [ERR_W-1:0]  w_err_nx;
   logic [1:0]        r_first;
   logic [1:0]        w_first_nx;
   logic [CNT_W-1:0]  r_samp;
   logic [CNT_W-1:0]  w_samp_nx;
   logic              r_pass;
   logic              w_pass_nx;
   logic              r_busy;
   logic              r_done;
   logic [1:0]        w_code;

   // State register
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state   <= S_IDLE;
         r_arm_cnt <= 1'b0;
      end else begin
         r_state   <= w_state_nx;
         r_arm_cnt <= w_arm_cnt_nx;
      end
   end

   // Next-state: ARM lasts exactly two cycles; start wins in IDLE/DONE, stop wins in CHECK
   always_comb begin
      w_state_nx   = r_state;
      w_arm_cnt_nx = r_arm_cnt;
      w_arm_entry  = 1'b0;
      w_model_upd  = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (bus.i_start) begin
               w_state_nx   = S_ARM;
               w_arm_cnt_nx = 1'b0;
               w_arm_entry  = 1'b1;
            end
         end
         S_ARM: begin
            w_model_upd  = 1'b1;
            w_arm_cnt_nx = 1'b1;
            if (r_arm_cnt) begin
               w_state_nx = S_CHECK;
            end
         end
         S_CHECK: begin
            w_model_upd = 1'b1;
            if (bus.i_stop) begin
               w_state_nx = S_DONE;
            end
         end
         S_DONE: begin
            if (bus.i_start) begin
               w_state_nx   = S_ARM;
               w_arm_cnt_nx = 1'b0;
               w_arm_entry  = 1'b1;
            end
         end
         default: w_state_nx = S_IDLE;
      endcase
   end

   // Reference latch model and its settle-delay shift registers
   always_comb begin
      w_exp_nx    = r_exp;
      w_gate_nx   = r_gate;
      w_mvalid_nx = r_mvalid;
      if (w_arm_entry) begin
         w_exp_nx    = '0;
         w_gate_nx   = '0;
         w_mvalid_nx = '0;
      end else if (w_model_upd) begin
         for (int i = SETTLE - 1; i > 0; i--) begin
            w_exp_nx[i]    = r_exp[i-1];
            w_gate_nx[i]   = r_gate[i-1];
            w_mvalid_nx[i] = r_mvalid[i-1];
         end
         w_exp_nx[0]    = bus.i_en ? bus.i_d : r_exp[0];
         w_gate_nx[0]   = bus.i_en;
         w_mvalid_nx[0] = r_mvalid[0] | bus.i_en;
      end
   end

   // Violation classification; complement error outranks follow/hold
   always_comb begin
      w_code = C_NONE;
      if (bus.i_q_bar == bus.i_q) begin
         w_code = C_COMPL;
      end else if (r_mvalid[SETTLE-1] && (bus.i_q != r_exp[SETTLE-1])) begin
         w_code = r_gate[SETTLE-1] ? C_FOLLOW : C_HOLD;
      end
   end

   // Result counters; verdict is taken from the count including the stop-cycle sample
   always_comb begin
      w_err_nx   = r_err;
      w_first_nx = r_first;
      w_samp_nx  = r_samp;
      w_pass_nx  = r_pass;
      if (w_arm_entry) begin
         w_err_nx   = '0;
         w_first_nx = C_NONE;
         w_samp_nx  = '0;
         w_pass_nx  = 1'b0;
      end else if (r_state == S_CHECK) begin
         if (r_samp != CNT_MAX) begin
            w_samp_nx = r_samp + CNT_W'(1);
         end
         if (w_code != C_NONE) begin
            if (r_err != ERR_MAX) begin
               w_err_nx = r_err + ERR_W'(1);
            end
            if (r_first == C_NONE) begin
               w_first_nx = w_code;
            end
         end
         if (w_state_nx == S_DONE) begin
            w_pass_nx = (w_err_nx == '0);
         end
      end
   end

   // Datapath and registered outputs
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_exp    <= '0;
         r_gate   <= '0;
         r_mvalid <= '0;
         r_err    <= '0;
         r_first  <= C_NONE;
         r_samp   <= '0;
         r_pass   <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_exp    <= w_exp_nx;
         r_gate   <= w_gate_nx;
         r_mvalid <= w_mvalid_nx;
         r_err    <= w_err_nx;
         r_first  <= w_first_nx;
         r_samp   <= w_samp_nx;
         r_pass   <= w_pass_nx;
         r_busy   <= (w_state_nx == S_ARM) || (w_state_nx == S_CHECK);
         r_done   <= (w_state_nx == S_DONE);
      end
   end

   assign bus.o_busy         = r_busy;
   assign bus.o_done         = r_done;
   assign bus.o_pass         = r_pass;
   assign bus.o_err_count    = r_err;
   assign bus.o_first_err    = r_first;
   assign bus.o_sample_count = r_samp;

endmodule
